// File: rtl/consol_arbiter_if.sv
//-----------------------------------------------------------------------------
// consol_arbiter_if
//
// Purpose : Bundles every non-clock signal of consol_arbiter. It carries
//           two symbol requesters (s0/s1), the link to the shared
//           data_consolidation instance (din/din_en out, dout/dout_en in),
//           the routed byte output (m_*) and status flags.
//
// Modports:
//   slave  - the arbiter side. It receives requester symbols and
//            consolidated bytes. It drives ready, din, the routed byte and
//            the status flags.
//   master - the environment side. It holds the requesters and
//            data_consolidation, and drives the opposite directions.
//
// Signals:
//   s0_valid/s0_data[1:0]/s0_ready  requester 0 symbol handshake
//   s1_valid/s1_data[1:0]/s1_ready  requester 1 symbol handshake
//   din[1:0]/din_en                 symbol + strobe to data_consolidation
//   dout[7:0]/dout_en               byte + strobe from data_consolidation
//   m_data[7:0]/m_id/m_valid        routed byte, owner index, 1-cycle strobe
//   busy                            arbiter is mid-byte
//   tag_err                         sticky: byte arrived with no owner tag
//-----------------------------------------------------------------------------
interface consol_arbiter_if;

  logic       s0_valid;
  logic [1:0] s0_data;
  logic       s0_ready;

  logic       s1_valid;
  logic [1:0] s1_data;
  logic       s1_ready;

  logic [1:0] din;
  logic       din_en;

  logic [7:0] dout;
  logic       dout_en;

  logic [7:0] m_data;
  logic       m_id;
  logic       m_valid;

  logic       busy;
  logic       tag_err;

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, dout, dout_en,
    output s0_ready, s1_ready, din, din_en, m_data, m_id, m_valid,
           busy, tag_err
  );

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, dout, dout_en,
    input  s0_ready, s1_ready, din, din_en, m_data, m_id, m_valid,
           busy, tag_err
  );

endinterface

// File: rtl/consol_arbiter.sv
//-----------------------------------------------------------------------------
// consol_arbiter
//
// Purpose : Shares one data_consolidation instance (four 2-bit symbols in,
//           one byte out, MSB symbol first) between two requesters.
//           - A grant covers one whole byte, so symbols from different
//             requesters are never interleaved inside a byte.
//           - Each granted byte pushes its owner index into a small tag
//             FIFO.
//           - When data_consolidation returns the byte (dout_en), the head
//             tag is popped and travels with the byte as m_id.
//
// Parameters:
//   TAG_DEPTH  depth of the owner-tag FIFO (power of 2, >= 2), default 4
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset. At integration, drive the
//              rstn of data_consolidation with ~rst so that a partial byte
//              is discarded on both sides together.
//   bus        consol_arbiter_if.slave (see the interface file for signals)
//
// Configuration macro:
//   CONSOL_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a
//                             contended grant. Otherwise the grant is
//                             round-robin, starting with requester 0.
//-----------------------------------------------------------------------------
module consol_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  consol_arbiter_if.slave  bus
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Arbitration state
  logic [0:0]           r_state;
  logic                 r_owner;
  logic                 r_last_owner;
  logic [1:0]           r_sym_cnt;

  // Owner-tag FIFO
  logic [TAG_DEPTH-1:0] r_tags;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  // Registered outputs
  logic [1:0]           r_din;
  logic                 r_din_en;
  logic [7:0]           r_m_data;
  logic                 r_m_id;
  logic                 r_m_valid;
  logic                 r_tag_err;

  // Combinational helpers
  logic                 w_busy;
  logic                 w_owner_valid;
  logic [1:0]           w_owner_data;
  logic                 w_xfer;
  logic                 w_byte_done;
  logic                 w_has_room;
  logic                 w_grant;
  logic                 w_next_owner;
  logic                 w_fifo_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_tag;

  //---------------------------------------------------------------------------
  // Handshake and FIFO control
  //---------------------------------------------------------------------------
  assign w_busy        = (r_state == ST_BUSY);
  assign w_owner_valid = r_owner ? bus.s1_valid : bus.s0_valid;
  assign w_owner_data  = r_owner ? bus.s1_data  : bus.s0_data;

  // Only the owner sees ready. A non-owner is held off even while the owner
  // stalls mid-byte. This keeps each byte built from a single requester.
  assign w_xfer      = w_busy & w_owner_valid;
  assign w_byte_done = w_xfer & (r_sym_cnt == 2'd3);

  // Only one byte can be in flight between grant and push. Checking the
  // room at grant time therefore reserves the slot that the push uses later,
  // and a byte that is already granted can always finish.
  assign w_has_room = (r_count < DEPTH_C);
  assign w_grant    = (r_state == ST_IDLE) & (bus.s0_valid | bus.s1_valid)
                      & w_has_room;

  assign w_fifo_empty = (r_count == '0);
  assign w_push       = w_byte_done;
  assign w_pop        = bus.dout_en & ~w_fifo_empty;
  assign w_head_tag   = r_tags[r_rd_ptr];

  // NOTE: every signal assigned in always_comb gets a default first, so
  // that no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next_owner = 1'b0;
`ifdef CONSOL_ARB_FIXED_PRIO_EN
    if (!bus.s0_valid) begin
      w_next_owner = 1'b1;
    end
`else
    if (bus.s0_valid && bus.s1_valid) begin
      w_next_owner = ~r_last_owner;
    end else if (bus.s1_valid) begin
      w_next_owner = 1'b1;
    end
`endif
  end

  //---------------------------------------------------------------------------
  // FSM: IDLE waits for a requester and FIFO room. BUSY moves exactly four
  // symbols from the owner.
  //---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_sym_cnt    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_BUSY;
            r_owner <= w_next_owner;
          end
        end
        ST_BUSY: begin
          if (w_xfer) begin
            // The 2-bit counter wraps to 0 on the fourth symbol.
            r_sym_cnt <= r_sym_cnt + 2'd1;
            if (w_byte_done) begin
              r_last_owner <= r_owner;
              r_state      <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Symbol path to data_consolidation. din holds its value between
  // transfers; din_en pulses once per accepted symbol.
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din    <= 2'd0;
      r_din_en <= 1'b0;
    end else begin
      r_din_en <= w_xfer;
      if (w_xfer) begin
        r_din <= w_owner_data;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Owner-tag FIFO
  //---------------------------------------------------------------------------
  // NOTE: the tag storage has no reset. A slot is read only when r_count
  // shows it was written, so clearing the array would add logic and change
  // nothing that can be observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= r_owner;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo TAG_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  //---------------------------------------------------------------------------
  // Routed byte output.
  // - Every dout_en yields one m_valid pulse.
  // - A byte that arrives with no tag queued is still forwarded, as
  //   requester 0. It also latches the sticky tag_err flag.
  // - A pop in the same cycle as a push reads the old head, so the tag
  //   being written is never bypassed to the output.
  //---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data  <= 8'd0;
      r_m_id    <= 1'b0;
      r_m_valid <= 1'b0;
      r_tag_err <= 1'b0;
    end else begin
      r_m_valid <= bus.dout_en;
      if (bus.dout_en) begin
        r_m_data <= bus.dout;
        r_m_id   <= w_fifo_empty ? 1'b0 : w_head_tag;
        if (w_fifo_empty) begin
          r_tag_err <= 1'b1;
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Output drive
  //---------------------------------------------------------------------------
  assign bus.s0_ready = w_busy & ~r_owner;
  assign bus.s1_ready = w_busy &  r_owner;
  assign bus.din      = r_din;
  assign bus.din_en   = r_din_en;
  assign bus.m_data   = r_m_data;
  assign bus.m_id     = r_m_id;
  assign bus.m_valid  = r_m_valid;
  assign bus.busy     = w_busy;
  assign bus.tag_err  = r_tag_err;

endmodule

// File: tb/tb_consol_arbiter.sv
//-----------------------------------------------------------------------------
// tb_consol_arbiter
//
// Self-checking bench for consol_arbiter.
// - Two queued requesters and a behavioural data_consolidation model run on
//   the falling edge.
// - The model assembles four symbols per byte, MSB first. It returns each
//   byte when allowed, either freely or one credit at a time.
// - A table of single-byte vectors comes first. Hand-written sequences then
//   cover contention, stall, backpressure, reset mid-byte and a spurious
//   dout_en.
//-----------------------------------------------------------------------------
module tb_consol_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  consol_arbiter_if bus ();

  consol_arbiter #(.TAG_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } res_t;

  typedef struct {
    logic       req;
    logic [1:0] a, b, c, d;     // symbols in send order (MSB first)
    logic [7:0] exp_data;
    logic       exp_id;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;

  logic [1:0]  q0[$];
  logic [1:0]  q1[$];
  logic [7:0]  cq[$];
  res_t        rq[$];
  int          din_cnt = 0;
  bit          cons_free = 1'b1;
  int          credit = 0;
  bit          spur = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  //---------------------------------------------------------------------------
  // Environment: requesters, data_consolidation model and result monitor
  //---------------------------------------------------------------------------
  initial begin : env
    logic [7:0] shift;
    logic [1:0] tmp;
    int         nsym;
    bit         c0, c1;
    shift = 8'd0; nsym = 0; c0 = 1'b0; c1 = 1'b0;
    bus.s0_valid = 1'b0; bus.s0_data = 2'd0;
    bus.s1_valid = 1'b0; bus.s1_data = 2'd0;
    bus.dout = 8'd0;     bus.dout_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete(); q1.delete(); cq.delete(); rq.delete();
        din_cnt = 0; shift = 8'd0; nsym = 0; c0 = 1'b0; c1 = 1'b0;
        spur = 1'b0;
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        bus.dout_en = 1'b0;
      end else begin
        if (bus.m_valid) rq.push_back({bus.m_id, bus.m_data});
        if (bus.din_en) begin
          din_cnt++;
          shift = {shift[5:0], bus.din};
          nsym++;
          if (nsym == 4) begin
            cq.push_back(shift);
            nsym = 0;
          end
        end
        if (c0) tmp = q0.pop_front();
        if (c1) tmp = q1.pop_front();
        bus.s0_valid = (q0.size() > 0);
        bus.s0_data  = bus.s0_valid ? q0[0] : 2'd0;
        bus.s1_valid = (q1.size() > 0);
        bus.s1_data  = bus.s1_valid ? q1[0] : 2'd0;
        // ready depends only on registered state, so it is already stable
        c0 = bus.s0_valid && bus.s0_ready;
        c1 = bus.s1_valid && bus.s1_ready;
        if (spur) begin
          bus.dout    = 8'hA5;
          bus.dout_en = 1'b1;
          spur        = 1'b0;
        end else if (cq.size() > 0 && (cons_free || credit > 0)) begin
          bus.dout    = cq.pop_front();
          bus.dout_en = 1'b1;
          if (!cons_free) credit--;
        end else begin
          bus.dout_en = 1'b0;
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Helpers (main thread acts 1 ns after each rising edge)
  //---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input int n, input int budget, input string name);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (rq.size() < n) check(name, rq.size(), n);
  endtask

  task automatic wait_din(input int n, input int budget, input string name);
    int k = 0;
    while (din_cnt < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (din_cnt < n) check(name, din_cnt, n);
  endtask

  task automatic push_sym(input bit req, input logic [1:0] s);
    if (req) q1.push_back(s);
    else     q0.push_back(s);
  endtask

  //---------------------------------------------------------------------------
  // Main sequence
  //---------------------------------------------------------------------------
  initial begin : main
    vec_t vt [6];
    logic exp_ids [8];
    logic [7:0] bp_bytes [5];
    int   d0;
    int   bad;

    vt[0] = '{1'b0, 2'd2, 2'd1, 2'd3, 2'd0, 8'h9C, 1'b0};
    vt[1] = '{1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b1};
    vt[2] = '{1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0};
    vt[3] = '{1'b1, 2'd1, 2'd2, 2'd3, 2'd0, 8'h6C, 1'b1};
    vt[4] = '{1'b0, 2'd3, 2'd0, 2'd0, 2'd1, 8'hC1, 1'b0};
    vt[5] = '{1'b1, 2'd0, 2'd3, 2'd2, 2'd1, 8'h39, 1'b1};

`ifdef CONSOL_ARB_FIXED_PRIO_EN
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

    bp_bytes = '{8'h1B, 8'hE4, 8'h55, 8'hAA, 8'h9C};

    // Reset state, checked while rst is held high and before the first edge
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst busy",     bus.busy,     0);
    check("rst din_en",   bus.din_en,   0);
    check("rst din",      bus.din,      0);
    check("rst m_valid",  bus.m_valid,  0);
    check("rst m_id",     bus.m_id,     0);
    check("rst m_data",   bus.m_data,   0);
    check("rst tag_err",  bus.tag_err,  0);
    check("rst s0_ready", bus.s0_ready, 0);
    check("rst s1_ready", bus.s1_ready, 0);
    do_reset();

    // Single-byte vectors
    for (int i = 0; i < 6; i++) begin
      rq.delete();
      d0 = din_cnt;
      push_sym(vt[i].req, vt[i].a);
      push_sym(vt[i].req, vt[i].b);
      push_sym(vt[i].req, vt[i].c);
      push_sym(vt[i].req, vt[i].d);
      wait_res(1, 60, $sformatf("vec%0d timeout", i));
      cyc(2);
      if (rq.size() >= 1) begin
        check($sformatf("vec%0d m_data", i), rq[0].data, vt[i].exp_data);
        check($sformatf("vec%0d m_id", i),   rq[0].id,   vt[i].exp_id);
      end
      check($sformatf("vec%0d din_en cnt", i), din_cnt - d0, 4);
      check($sformatf("vec%0d m_valid cnt", i), rq.size(), 1);
      check($sformatf("vec%0d busy", i), bus.busy, 0);
    end
    check("vec tag_err", bus.tag_err, 0);

    // Contention: s0 sends 0xFF bytes, s1 sends 0x00 bytes, both always valid
    do_reset();
    for (int i = 0; i < 16; i++) begin
      q0.push_back(2'd3);
      q1.push_back(2'd0);
    end
    wait_res(8, 200, "contention timeout");
    if (rq.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("cont%0d m_id", i), rq[i].id, exp_ids[i]);
        check($sformatf("cont%0d m_data", i), rq[i].data,
              exp_ids[i] ? 8'h00 : 8'hFF);
      end
    end

    // Stall: s0 owns the byte, sends 2 symbols, then goes quiet while s1 waits
    do_reset();
    q0.push_back(2'd1); q0.push_back(2'd0);
    for (int i = 0; i < 4; i++) q1.push_back(2'd2);
    wait_din(2, 40, "stall first symbols timeout");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.s1_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      cyc(1);
    end
    check("stall grant held", bad, 0);
    check("stall din_en cnt", din_cnt, 2);
    q0.push_back(2'd3); q0.push_back(2'd2);
    wait_res(2, 60, "stall timeout");
    if (rq.size() >= 2) begin
      check("stall byte0 m_id",   rq[0].id,   0);
      check("stall byte0 m_data", rq[0].data, 8'h4E);
      check("stall byte1 m_id",   rq[1].id,   1);
      check("stall byte1 m_data", rq[1].data, 8'hAA);
    end

    // Backpressure: no dout_en until the FIFO holds four tags
    do_reset();
    cons_free = 1'b0;
    credit    = 0;
    for (int b = 0; b < 5; b++) begin
      for (int s = 3; s >= 0; s--) begin
        logic [7:0] byte_v;
        byte_v = bp_bytes[b];
        q0.push_back(byte_v[2*s +: 2]);
      end
    end
    wait_din(16, 100, "backpressure fill timeout");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy !== 1'b0 || bus.s0_ready !== 1'b0) bad++;
      cyc(1);
    end
    check("bp grant blocked", bad, 0);
    check("bp din_en cnt full", din_cnt, 16);
    check("bp no output", rq.size(), 0);
    credit = 1;
    wait_res(1, 20, "bp one-pop timeout");
    wait_din(20, 40, "bp freed grant timeout");
    check("bp din_en cnt after pop", din_cnt, 20);
    cons_free = 1'b1;
    wait_res(5, 60, "bp drain timeout");
    if (rq.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp%0d m_data", i), rq[i].data, bp_bytes[i]);
        check($sformatf("bp%0d m_id", i),   rq[i].id,   0);
      end
    end

    // Reset after 3 symbols of a byte (m_data still holds 0x9C here)
    q0.push_back(2'd3); q0.push_back(2'd2); q0.push_back(2'd1);
    wait_din(23, 40, "mid-byte symbols timeout");
    check("pre-rst busy", bus.busy, 1);
    check("pre-rst din",  bus.din,  1);
    rst = 1'b1;
    #1;
    check("mid rst busy",     bus.busy,     0);
    check("mid rst din",      bus.din,      0);
    check("mid rst din_en",   bus.din_en,   0);
    check("mid rst s0_ready", bus.s0_ready, 0);
    check("mid rst m_data",   bus.m_data,   0);
    check("mid rst m_id",     bus.m_id,     0);
    check("mid rst m_valid",  bus.m_valid,  0);
    check("mid rst tag_err",  bus.tag_err,  0);
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back(2'd1);
    wait_res(1, 60, "post-rst byte timeout");
    if (rq.size() >= 1) begin
      check("post-rst m_data", rq[0].data, 8'h55);
      check("post-rst m_id",   rq[0].id,   0);
    end
    check("post-rst tag_err", bus.tag_err, 0);

    // Spurious dout_en with an empty tag FIFO
    do_reset();
    spur = 1'b1;
    wait_res(1, 10, "spurious timeout");
    if (rq.size() >= 1) begin
      check("spur m_id",   rq[0].id,   0);
      check("spur m_data", rq[0].data, 8'hA5);
    end
    check("spur tag_err", bus.tag_err, 1);
    q1.push_back(2'd0); q1.push_back(2'd3);
    q1.push_back(2'd2); q1.push_back(2'd1);
    wait_res(2, 60, "spur follow-up timeout");
    if (rq.size() >= 2) begin
      check("spur next m_id",   rq[1].id,   1);
      check("spur next m_data", rq[1].data, 8'h39);
    end
    check("spur tag_err sticky", bus.tag_err, 1);
    do_reset();
    check("tag_err cleared", bus.tag_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/consol_arbiter.md
CONSOL_ARBITER -- requirements
Module: consol_arbiter

Interface
REQ-001 Parameter: TAG_DEPTH, default 4, depth of the owner-tag FIFO (power of 2, >=2).
REQ-002 Port: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: s0_valid  input  1  requester 0 symbol valid.
REQ-005 Port: s0_data  input  2  requester 0 2-bit symbol.
REQ-006 Port: s0_ready  output  1  requester 0 symbol accepted.
REQ-007 Port: s1_valid / s1_data / s1_ready  input 1 / input 2 / output 1  requester 1, same meaning as requester 0.
REQ-008 Port: din  output  2  symbol to data_consolidation.
REQ-009 Port: din_en  output  1  symbol strobe to data_consolidation.
REQ-010 Port: dout  input  8  byte from data_consolidation.
REQ-011 Port: dout_en  input  1  byte strobe from data_consolidation.
REQ-012 Port: m_data  output  8  routed byte.
REQ-013 Port: m_id  output  1  requester index owning m_data.
REQ-014 Port: m_valid  output  1  m_data/m_id valid, one-cycle pulse.
REQ-015 Port: busy  output  1  high while in BUSY state.
REQ-016 Port: tag_err  output  1  sticky: dout_en arrived with tag FIFO empty.

Function
REQ-017 The block SHALL share one data_consolidation instance between two requesters, one whole byte (4 symbols, MSB symbol first) per grant, never interleaving requesters within a byte.
REQ-018 FSM states SHALL be IDLE and BUSY; registers: owner (1b), last_owner (1b), sym_cnt (2b).
REQ-019 IDLE->BUSY SHALL occur when any sN_valid is high and tag FIFO count < TAG_DEPTH; owner is latched on that edge.
REQ-020 Arbitration SHALL be round-robin: both valid -> owner = ~last_owner; one valid -> that requester.
REQ-021 sN_ready SHALL be combinational: high only when state==BUSY and owner==N.
REQ-022 A symbol transfer SHALL occur when sN_valid & sN_ready; din <= sN_data and din_en <= 1 on that edge (1-cycle latency); din_en SHALL be 0 in any cycle without a transfer; din holds its last value.
REQ-023 sym_cnt SHALL increment per transfer; on the transfer with sym_cnt==3: push owner into tag FIFO, last_owner <= owner, sym_cnt <= 0, state <= IDLE.
REQ-024 Owner deasserting valid mid-byte SHALL stall in BUSY indefinitely; no timeout, no grant change.
REQ-025 On dout_en: pop tag FIFO; m_data <= dout, m_id <= head tag, m_valid <= 1 on the next edge (1-cycle latency); m_valid = 0 otherwise.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; pop reads the pre-push head; FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-027 dout_en with FIFO empty SHALL set tag_err, output m_valid with m_id = 0, and not move pointers.
REQ-028 Full FIFO SHALL block only new grants; a byte already in BUSY SHALL complete (count reserved at grant, so overflow is impossible).
REQ-029 busy SHALL equal (state==BUSY).

Reset
REQ-030 rst high SHALL immediately force: state IDLE, owner 0, last_owner 1 (requester 0 wins first), sym_cnt 0, FIFO empty, din 0, din_en 0, m_data 0, m_id 0, m_valid 0, tag_err 0.
REQ-031 Reset mid-byte SHALL discard the partial byte; integration SHALL drive data_consolidation rstn = ~rst so both clear together.

Configuration
REQ-032 Macro CONSOL_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (requester 0 wins whenever s0_valid); when undefined, round-robin per REQ-020; all other behaviour identical.

Verification
REQ-033 Single: s0 sends 2,1,3,0 back-to-back -> din_en 4 cycles, then m_data=0x9C, m_id=0, m_valid 1 cycle.
REQ-034 Contention: both valid continuously, bytes 0xFF (s0) / 0x00 (s1) -> m_id sequence 0,1,0,1; bytes never mixed (fixed prio build: 0,0,0,0).
REQ-035 Stall: s0 drops valid after 2 symbols for 10 cycles while s1 valid -> s1_ready stays 0, s0 byte completes intact.
REQ-036 Backpressure: dout_en held off until 4 bytes tagged -> busy stays 0 with requesters valid; one dout_en frees one grant.
REQ-037 Reset mid-byte after 3 symbols -> all outputs at reset values within the reset cycle; next byte correct, no tag_err.
REQ-038 Spurious dout_en with empty FIFO -> tag_err=1 and stays 1 until rst.
